thread_state_store: RTL and testbench

//  Per-thread save/restore storage for the sha256 engine's process_bytes unit.

---
 rtl/thread_state_store_pkg.sv | 16 +
 rtl/thread_valid_tracker.sv | 56 +++++
 rtl/thread_state_store.sv | 93 +++++++++
 tb/tb_thread_state_store.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/thread_state_store_pkg.sv
// rtl/thread_state_store_pkg.sv - shared widths and index helpers for the per-thread save/restore store
package thread_state_store_pkg;

   localparam int PROCB_SAVE_WIDTH = 64;

   // Highest set bit of v; 0 when v is 0, so a single-slot store still gets a 1-bit index.
   function automatic int msb(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/thread_valid_tracker.sv
// rtl/thread_valid_tracker.sv - per-slot valid flags, occupancy count and empty flag
module thread_valid_tracker
   import thread_state_store_pkg::*;
#(
   parameter int N_THREADS     = 6,
   parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     wr_en,
   input  logic [N_THREADS_MSB:0]   wr_thread_num,
   input  logic                     inv_en,
   input  logic [N_THREADS_MSB:0]   inv_thread_num,
   output logic [N_THREADS-1:0]     valid,
   output logic [N_THREADS_MSB+1:0] n_valid,
   output logic                     all_empty
);

   localparam int IDX_W = N_THREADS_MSB + 1;
   localparam int CNT_W = N_THREADS_MSB + 2;

   logic [N_THREADS-1:0] valid_next;
   logic [CNT_W-1:0]     count_next;
   logic                 wr_ok;
   logic                 inv_ok;

   assign wr_ok  = wr_en  && ({1'b0, wr_thread_num}  < (IDX_W + 1)'(N_THREADS));
   assign inv_ok = inv_en && ({1'b0, inv_thread_num} < (IDX_W + 1)'(N_THREADS));

   // Write beats invalidate on the same slot; counting the next vector nets simultaneous events.
   always_comb begin
      valid_next = valid;
      count_next = '0;
      for (int i = 0; i < N_THREADS; i++) begin
         if (wr_ok && (wr_thread_num == IDX_W'(i))) begin
            valid_next[i] = 1'b1;
         end else if (inv_ok && (inv_thread_num == IDX_W'(i))) begin
            valid_next[i] = 1'b0;
         end
         count_next = count_next + CNT_W'(valid_next[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid     <= '0;
         n_valid   <= '0;
         all_empty <= 1'b1;
      end else begin
         valid     <= valid_next;
         n_valid   <= count_next;
         all_empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/thread_state_store.sv
// rtl/thread_state_store.sv - per-thread record RAM with valid masking and optional registered read
module thread_state_store
   import thread_state_store_pkg::*;
#(
   parameter int N_THREADS     = 6,
   parameter int N_THREADS_MSB = msb(N_THREADS - 1),
   parameter int WIDTH         = PROCB_SAVE_WIDTH,
   parameter int REG_OUT       = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     wr_en,
   input  logic [N_THREADS_MSB:0]   wr_thread_num,
   input  logic [WIDTH-1:0]         din,
   input  logic                     inv_en,
   input  logic [N_THREADS_MSB:0]   inv_thread_num,
   input  logic                     rd_en,
   input  logic [N_THREADS_MSB:0]   rd_thread_num,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic [N_THREADS_MSB+1:0] n_valid,
   output logic                     all_empty
);

   localparam int IDX_W = N_THREADS_MSB + 1;

   logic [WIDTH-1:0]     mem [N_THREADS];
   logic [N_THREADS-1:0] valid;
   logic                 wr_ok;
   logic                 inv_ok;
   logic                 rd_ok;
   logic                 stored_valid;
   logic [WIDTH-1:0]     stored_data;

   assign wr_ok  = wr_en  && ({1'b0, wr_thread_num}  < (IDX_W + 1)'(N_THREADS));
   assign inv_ok = inv_en && ({1'b0, inv_thread_num} < (IDX_W + 1)'(N_THREADS));
   assign rd_ok  = ({1'b0, rd_thread_num} < (IDX_W + 1)'(N_THREADS));

   thread_valid_tracker #(
      .N_THREADS     (N_THREADS),
      .N_THREADS_MSB (N_THREADS_MSB)
   ) u_tracker (
      .CLK            (CLK),
      .RST            (RST),
      .wr_en          (wr_en),
      .wr_thread_num  (wr_thread_num),
      .inv_en         (inv_en),
      .inv_thread_num (inv_thread_num),
      .valid          (valid),
      .n_valid        (n_valid),
      .all_empty      (all_empty)
   );

   // No reset on the RAM: stale contents are hidden by the cleared valid flags.
   always_ff @(posedge CLK) begin
      if (!RST && wr_ok) mem[wr_thread_num] <= din;
   end

   assign stored_valid = rd_ok && valid[rd_thread_num];
   assign stored_data  = stored_valid ? mem[rd_thread_num] : '0;

   generate
      if (REG_OUT == 0) begin : g_comb_read
         assign dout       = stored_data;
         assign dout_valid = stored_valid;
      end else begin : g_reg_read
         logic [WIDTH-1:0] dout_q;
         logic             dout_valid_q;

         always_ff @(posedge CLK) begin
            if (RST) begin
               dout_q       <= '0;
               dout_valid_q <= 1'b0;
            end else if (rd_en) begin
               if (wr_ok && (wr_thread_num == rd_thread_num)) begin
                  dout_q       <= din;
                  dout_valid_q <= 1'b1;
               end else if (inv_ok && (inv_thread_num == rd_thread_num)) begin
                  dout_q       <= '0;
                  dout_valid_q <= 1'b0;
               end else begin
                  dout_q       <= stored_data;
                  dout_valid_q <= stored_valid;
               end
            end
         end

         assign dout       = dout_q;
         assign dout_valid = dout_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_thread_state_store.sv
// tb/tb_thread_state_store.sv - directed bench driving a combinational-read and a registered-read instance in lockstep
module tb_thread_state_store;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_thread_num;
   logic [63:0] din;
   logic        inv_en;
   logic [2:0]  inv_thread_num;
   logic        rd_en;
   logic [2:0]  rd_thread_num;

   logic [63:0] dout0, dout1;
   logic        dv0, dv1;
   logic [3:0]  nv0, nv1;
   logic        ae0, ae1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   thread_state_store #(.N_THREADS(6), .WIDTH(64), .REG_OUT(0)) u0 (
      .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_thread_num(wr_thread_num), .din(din),
      .inv_en(inv_en), .inv_thread_num(inv_thread_num), .rd_en(rd_en),
      .rd_thread_num(rd_thread_num), .dout(dout0), .dout_valid(dv0),
      .n_valid(nv0), .all_empty(ae0)
   );

   thread_state_store #(.N_THREADS(6), .WIDTH(64), .REG_OUT(1)) u1 (
      .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_thread_num(wr_thread_num), .din(din),
      .inv_en(inv_en), .inv_thread_num(inv_thread_num), .rd_en(rd_en),
      .rd_thread_num(rd_thread_num), .dout(dout1), .dout_valid(dv1),
      .n_valid(nv1), .all_empty(ae1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_count(input string tag, input logic [3:0] exp_n);
      chk({tag, "_nv0"}, 64'(nv0), 64'(exp_n));
      chk({tag, "_nv1"}, 64'(nv1), 64'(exp_n));
      chk({tag, "_ae0"}, 64'(ae0), 64'(exp_n == 4'd0));
      chk({tag, "_ae1"}, 64'(ae1), 64'(exp_n == 4'd0));
   endtask

   task automatic idle();
      wr_en = 1'b0; inv_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; idle();
      wr_thread_num = 3'd0; inv_thread_num = 3'd0; rd_thread_num = 3'd0; din = '0;
      step(); step();
      rst = 1'b0;
      chk_count("reset", 4'd0);

      // 1: every slot reads empty after reset
      for (int s = 0; s < 6; s++) begin
         rd_thread_num = 3'(s); rd_en = 1'b1;
         step();
         chk($sformatf("t1_dout0_s%0d", s), dout0, 64'd0);
         chk($sformatf("t1_dv0_s%0d", s), 64'(dv0), 64'd0);
         chk($sformatf("t1_dout1_s%0d", s), dout1, 64'd0);
         chk($sformatf("t1_dv1_s%0d", s), 64'(dv1), 64'd0);
      end
      idle();

      // 2: write slot 2, then read it back
      wr_en = 1'b1; wr_thread_num = 3'd2; din = 64'hDEAD_BEEF_0000_0002;
      step();
      wr_en = 1'b0; rd_thread_num = 3'd2; rd_en = 1'b1;
      #1;
      chk("t2_dout0", dout0, 64'hDEAD_BEEF_0000_0002);
      chk("t2_dv0", 64'(dv0), 64'd1);
      step();
      rd_en = 1'b0;
      chk("t2_dout1", dout1, 64'hDEAD_BEEF_0000_0002);
      chk("t2_dv1", 64'(dv1), 64'd1);
      chk_count("t2", 4'd1);

      // 3: same-cycle write and read of slot 4
      wr_en = 1'b1; wr_thread_num = 3'd4; din = 64'h1234;
      rd_en = 1'b1; rd_thread_num = 3'd4;
      #1;
      chk("t3_dout0_old", dout0, 64'd0);
      chk("t3_dv0_old", 64'(dv0), 64'd0);
      step();
      idle();
      chk("t3_dout1_bypass", dout1, 64'h1234);
      chk("t3_dv1_bypass", 64'(dv1), 64'd1);
      chk("t3_dout0_after", dout0, 64'h1234);
      chk_count("t3", 4'd2);

      // registered output holds without rd_en
      rd_thread_num = 3'd2;
      step();
      chk("t3_hold", dout1, 64'h1234);

      // 4: write+invalidate on the same slot, then on different slots
      wr_en = 1'b1; wr_thread_num = 3'd3; din = 64'h33;
      step();
      chk_count("t4_fill", 4'd3);
      wr_en = 1'b1; wr_thread_num = 3'd3; din = 64'h55;
      inv_en = 1'b1; inv_thread_num = 3'd3;
      step();
      idle();
      rd_thread_num = 3'd3;
      #1;
      chk_count("t4_same", 4'd3);
      chk("t4_dout0_s3", dout0, 64'h55);
      chk("t4_dv0_s3", 64'(dv0), 64'd1);
      wr_en = 1'b1; wr_thread_num = 3'd0; din = 64'hA0;
      inv_en = 1'b1; inv_thread_num = 3'd3;
      step();
      idle();
      chk_count("t4_net", 4'd3);
      chk("t4_dout0_inv", dout0, 64'd0);
      chk("t4_dv0_inv", 64'(dv0), 64'd0);

      // invalidate bypass on the registered read
      inv_en = 1'b1; inv_thread_num = 3'd4; rd_en = 1'b1; rd_thread_num = 3'd4;
      step();
      idle();
      chk("t4_inv_byp_dout1", dout1, 64'd0);
      chk("t4_inv_byp_dv1", 64'(dv1), 64'd0);
      chk_count("t4_inv", 4'd2);

      // 5: fill all slots, invalidate slot 5 twice, out-of-range write
      for (int s = 0; s < 6; s++) begin
         wr_en = 1'b1; wr_thread_num = 3'(s); din = 64'h100 + 64'(s);
         step();
      end
      idle();
      chk_count("t5_full", 4'd6);
      inv_en = 1'b1; inv_thread_num = 3'd5;
      step();
      chk_count("t5_inv1", 4'd5);
      step();
      idle();
      chk_count("t5_inv2", 4'd5);
      wr_en = 1'b1; wr_thread_num = 3'd7; din = 64'hFFFF;
      rd_en = 1'b1; rd_thread_num = 3'd7;
      step();
      idle();
      chk_count("t5_oob_wr", 4'd5);
      chk("t5_oob_dout0", dout0, 64'd0);
      chk("t5_oob_dv0", 64'(dv0), 64'd0);
      chk("t5_oob_dout1", dout1, 64'd0);
      chk("t5_oob_dv1", 64'(dv1), 64'd0);

      // back-to-back reads, one result per cycle
      rd_en = 1'b1; rd_thread_num = 3'd1;
      step();
      chk("t5_b2b_1", dout1, 64'h101);
      rd_thread_num = 3'd4;
      step();
      rd_en = 1'b0;
      chk("t5_b2b_4", dout1, 64'h104);
      chk("t5_b2b_dv", 64'(dv1), 64'd1);

      // 6: reset with a concurrent write discards everything
      rst = 1'b1; wr_en = 1'b1; wr_thread_num = 3'd1; din = 64'hBAD;
      step();
      rst = 1'b0; idle();
      chk_count("t6_rst", 4'd0);
      chk("t6_rst_dout1", dout1, 64'd0);
      chk("t6_rst_dv1", 64'(dv1), 64'd0);
      rd_en = 1'b1; rd_thread_num = 3'd1;
      step();
      idle();
      chk("t6_dout0", dout0, 64'd0);
      chk("t6_dv0", 64'(dv0), 64'd0);
      chk("t6_dout1", dout1, 64'd0);
      chk("t6_dv1", 64'(dv1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
